id_decode_stage: RTL
====================

Name: id_decode_stage

Overview:
Parametrised RV32I instruction-decode pipeline stage. It sits between the IF stage and the EX stage and replaces the kick-up/initial-flag scheme with a valid/ready handshake. It captures one instruction and its PC per accepted transfer and registers the full decode: control bits, ALU op, funct3, register indices and a sign-extended immediate for all five RV32I immediate formats. It also detects load-use hazards against EX, inserting bubbles, and supports a flush from EX.

Parameters:
XLEN, 32, datapath width of out_pc/out_imm (must be >= 32; immediates sign-extended to XLEN)
RF_ADDR_W, 5, register index width (only low RF_ADDR_W bits of instruction fields used)
ALUOP_W, 4, width of out_aluop
HAZARD_EN, 1, 1 = load-use stall logic present; 0 = hazard forced to 0

Ports:
clk  in  1  clock
reset  in  1  reset
in_valid  in  1  IF presents instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  PC of in_instr
flush  in  1  EX redirect; kill held and incoming instruction
ex_memread  in  1  instruction currently in EX is a load
ex_rd  in  RF_ADDR_W  destination of EX instruction
out_valid  out  1  decoded instruction valid to EX
out_ready  in  1  EX accepts this cycle
out_pc  out  XLEN  captured PC
out_imm  out  XLEN  sign-extended immediate
out_rs1, out_rs2, out_rd  out  RF_ADDR_W each  register indices of captured instruction
out_funct3  out  3  instr[14:12]
out_aluop  out  ALUOP_W  ALU operation
out_branch, out_jump, out_memread, out_memwrite, out_memtoreg, out_alusrc, out_regwrite, out_illegal  out  1 each  control bits

Behaviour:
- Reset is asynchronous and active-high on reset; clock is clk. On reset, every registered output is 0: out_valid=0, all control bits, out_imm, out_pc, indices and aluop are 0. in_ready is 1 in the cycle after reset deasserts.
- Single holding register (valid_q plus decoded fields). Decode is computed from in_instr and registered on accept, so latency from accept to out_valid is 1 cycle.
- hazard = HAZARD_EN & valid_q & ex_memread & (ex_rd!=0) & ((ex_rd==out_rs1 & uses_rs1) | (ex_rd==out_rs2 & uses_rs2)).
  - uses_rs1: all opcodes except LUI, AUIPC, JAL.
  - uses_rs2: OP, BRANCH, STORE.
- out_valid = valid_q & ~hazard. During a hazard, EX sees a bubble and the held entry is kept unchanged.
- in_ready = ~flush & (~valid_q | (out_ready & ~hazard)). accept = in_valid & in_ready.
- Register update priority:
  1. flush: valid_q <= 0; fields are don't-care.
  2. accept: load new decode, valid_q <= 1.
  3. out_valid & out_ready: valid_q <= 0.
  4. Otherwise hold.
  Simultaneous drain and accept loads the new entry with no bubble, giving full throughput.
- Opcode decode (instr[6:0]):
  - OP_IMM 0010011: alusrc, regwrite.
  - OP 0110011: regwrite.
  - BRANCH 1100011: branch, aluop=SUB.
  - JAL 1101111: jump, regwrite.
  - JALR 1100111: jump, alusrc, regwrite.
  - LOAD 0000011: memread, memtoreg, alusrc, regwrite, aluop=ADD.
  - STORE 0100011: memwrite, alusrc, aluop=ADD.
  - LUI 0110111: alusrc, regwrite, aluop=PASSB.
  - AUIPC 0010111: alusrc, regwrite, aluop=ADD.
  - Any other opcode: out_illegal=1, all other control bits 0, imm 0. It still travels as valid so EX can trap.
  - regwrite is forced 0 when rd==0.
- aluop encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - OP: from funct3, with instr[30] selecting SUB/SRA.
  - OP_IMM: same, but instr[30] is honoured only for funct3=101 (SRAI); ADDI never gives SUB.
  - JAL/JALR: ADD.
- Immediates (sign bit instr[31], extended to XLEN):
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - OP: 0.
- Indices come from the captured instruction: rs1=[19:15], rs2=[24:20], rd=[11:7]. They are never taken live from in_instr.
- Flush while a hazard is active clears the entry. Flush has priority over a same-cycle accept, and the offered instruction is not consumed.
- Reset mid-stream drops the held entry immediately (asynchronous).

Test Plan:
- Reset, then in_valid=1, instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, aluop=0, alusrc=1, regwrite=1, out_rd=1.
- Back-to-back stream of beq 0x00208463 / sw 0xFE112E23 / jal 0x0080006F / lui 0x123450B7 with out_ready=1 → one per cycle, imm = 8, -4 (0xFFFFFFFC), 8, 0x12345000; branch/memwrite/jump set respectively.
- Held add x3,x1,x2 (0x002081B3) with ex_memread=1, ex_rd=2 for 2 cycles → out_valid=0 and in_ready=0 for 2 cycles; entry unchanged; out_valid=1 when ex_memread drops. Repeat with ex_rd=0 → no stall.
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out fields stable; release → exactly one transfer per cycle with no loss or duplication (scoreboard by PC).
- flush asserted with valid_q=1 and in_valid=1 → next cycle out_valid=0, offered instr not consumed (IF re-presents it); also assert reset mid-stall → out_valid=0 asynchronously.
- Opcode 0x0000007F and srai 0x4010D093, add x0,x1,x2 → illegal=1 with other controls 0; aluop=7 (SRA); regwrite=0 for rd=0.

Source files
------------

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: IF-side handshake, EX feedback and decoded-instruction bus of the decode stage
interface id_decode_stage_if #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int ALUOP_W   = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic [XLEN-1:0]      in_pc;
    logic                 flush;
    logic                 ex_memread;
    logic [RF_ADDR_W-1:0] ex_rd;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [XLEN-1:0]      out_imm;
    logic [RF_ADDR_W-1:0] out_rs1;
    logic [RF_ADDR_W-1:0] out_rs2;
    logic [RF_ADDR_W-1:0] out_rd;
    logic [2:0]           out_funct3;
    logic [ALUOP_W-1:0]   out_aluop;
    logic                 out_branch;
    logic                 out_jump;
    logic                 out_memread;
    logic                 out_memwrite;
    logic                 out_memtoreg;
    logic                 out_alusrc;
    logic                 out_regwrite;
    logic                 out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, ex_memread, ex_rd, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3,
               out_aluop, out_branch, out_jump, out_memread, out_memwrite, out_memtoreg,
               out_alusrc, out_regwrite, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, ex_memread, ex_rd, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd, out_funct3,
               out_aluop, out_branch, out_jump, out_memread, out_memwrite, out_memtoreg,
               out_alusrc, out_regwrite, out_illegal
    );
endinterface

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV32I decode stage with valid/ready handshake, load-use stall and EX flush
module id_decode_stage #(
    parameter int XLEN      = 32,
    parameter int RF_ADDR_W = 5,
    parameter int ALUOP_W   = 4,
    parameter bit HAZARD_EN = 1'b1
) (
    input logic               clk,
    input logic               reset,
    id_decode_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_SLL   = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_SRL   = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_SRA   = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(10);

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      imm;
        logic [RF_ADDR_W-1:0] rs1;
        logic [RF_ADDR_W-1:0] rs2;
        logic [RF_ADDR_W-1:0] rd;
        logic [2:0]           funct3;
        logic [ALUOP_W-1:0]   aluop;
        logic                 branch;
        logic                 jump;
        logic                 memread;
        logic                 memwrite;
        logic                 memtoreg;
        logic                 alusrc;
        logic                 regwrite;
        logic                 illegal;
        logic                 uses_rs1;
        logic                 uses_rs2;
    } dec_t;

    dec_t               dec_q, dec_d, dec_new;
    logic               valid_q, valid_d;
    logic [31:0]        ins;
    logic [6:0]         opc;
    logic [31:0]        imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
    logic [ALUOP_W-1:0] alu_f;
    logic               alt, hazard, out_valid, in_ready, accept;

    assign ins = bus.in_instr;
    assign opc = ins[6:0];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // OP-IMM only honours instr[30] for shifts, so ADDI can never become SUB
    always_comb begin
        alt = ins[30] & ((opc == OPC_OP) | (ins[14:12] == 3'b101));
        case (ins[14:12])
            3'b000:  alu_f = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_f = ALU_SLL;
            3'b010:  alu_f = ALU_SLT;
            3'b011:  alu_f = ALU_SLTU;
            3'b100:  alu_f = ALU_XOR;
            3'b101:  alu_f = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f = ALU_OR;
            default: alu_f = ALU_AND;
        endcase
    end

    always_comb begin
        dec_new          = '0;
        imm32            = '0;
        dec_new.pc       = bus.in_pc;
        dec_new.rs1      = RF_ADDR_W'(ins[19:15]);
        dec_new.rs2      = RF_ADDR_W'(ins[24:20]);
        dec_new.rd       = RF_ADDR_W'(ins[11:7]);
        dec_new.funct3   = ins[14:12];
        dec_new.uses_rs1 = 1'b1;
        case (opc)
            OPC_OP_IMM: begin
                dec_new.alusrc   = 1'b1;
                dec_new.regwrite = 1'b1;
                dec_new.aluop    = alu_f;
                imm32            = imm_i;
            end
            OPC_OP: begin
                dec_new.regwrite = 1'b1;
                dec_new.aluop    = alu_f;
                dec_new.uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                dec_new.branch   = 1'b1;
                dec_new.aluop    = ALU_SUB;
                dec_new.uses_rs2 = 1'b1;
                imm32            = imm_b;
            end
            OPC_JAL: begin
                dec_new.jump     = 1'b1;
                dec_new.regwrite = 1'b1;
                dec_new.uses_rs1 = 1'b0;
                imm32            = imm_j;
            end
            OPC_JALR: begin
                dec_new.jump     = 1'b1;
                dec_new.alusrc   = 1'b1;
                dec_new.regwrite = 1'b1;
                imm32            = imm_i;
            end
            OPC_LOAD: begin
                dec_new.memread  = 1'b1;
                dec_new.memtoreg = 1'b1;
                dec_new.alusrc   = 1'b1;
                dec_new.regwrite = 1'b1;
                imm32            = imm_i;
            end
            OPC_STORE: begin
                dec_new.memwrite = 1'b1;
                dec_new.alusrc   = 1'b1;
                dec_new.uses_rs2 = 1'b1;
                imm32            = imm_s;
            end
            OPC_LUI: begin
                dec_new.alusrc   = 1'b1;
                dec_new.regwrite = 1'b1;
                dec_new.aluop    = ALU_PASSB;
                dec_new.uses_rs1 = 1'b0;
                imm32            = imm_u;
            end
            OPC_AUIPC: begin
                dec_new.alusrc   = 1'b1;
                dec_new.regwrite = 1'b1;
                dec_new.uses_rs1 = 1'b0;
                imm32            = imm_u;
            end
            default: dec_new.illegal = 1'b1;
        endcase
        dec_new.imm      = XLEN'($signed(imm32));
        dec_new.regwrite = dec_new.regwrite & (dec_new.rd != '0);
    end

    // Hazard is judged against the held entry, never the instruction being offered
    always_comb begin
        hazard    = HAZARD_EN & valid_q & bus.ex_memread & (bus.ex_rd != '0) &
                    (((bus.ex_rd == dec_q.rs1) & dec_q.uses_rs1) |
                     ((bus.ex_rd == dec_q.rs2) & dec_q.uses_rs2));
        out_valid = valid_q & ~hazard;
        in_ready  = ~bus.flush & (~valid_q | (bus.out_ready & ~hazard));
        accept    = bus.in_valid & in_ready;
        valid_d   = bus.flush ? 1'b0 :
                    accept ? 1'b1 :
                    (out_valid & bus.out_ready) ? 1'b0 : valid_q;
        dec_d     = accept ? dec_new : dec_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    assign bus.out_pc       = dec_q.pc;
    assign bus.out_imm      = dec_q.imm;
    assign bus.out_rs1      = dec_q.rs1;
    assign bus.out_rs2      = dec_q.rs2;
    assign bus.out_rd       = dec_q.rd;
    assign bus.out_funct3   = dec_q.funct3;
    assign bus.out_aluop    = dec_q.aluop;
    assign bus.out_branch   = dec_q.branch;
    assign bus.out_jump     = dec_q.jump;
    assign bus.out_memread  = dec_q.memread;
    assign bus.out_memwrite = dec_q.memwrite;
    assign bus.out_memtoreg = dec_q.memtoreg;
    assign bus.out_alusrc   = dec_q.alusrc;
    assign bus.out_regwrite = dec_q.regwrite;
    assign bus.out_illegal  = dec_q.illegal;
endmodule
